// File: rtl/aq_vfmau_wb_collect_pkg.sv
// Shared types and constants for the FMA writeback collector.
//   - lat class encoding for the completion stage of an allocation
//   - fflags bit positions (NV,DZ,OF,UF,NX)
//   - per-entry state struct (the destination tag is kept beside it, sized by the top)
package aq_vfmau_wb_collect_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned FF_W   = 5;
    localparam int unsigned LAT_W  = 2;
    localparam int unsigned NSTAGE = 3;

    localparam logic [LAT_W-1:0] LAT_EX3 = 2'd0;
    localparam logic [LAT_W-1:0] LAT_EX4 = 2'd1;
    localparam logic [LAT_W-1:0] LAT_EX5 = 2'd2;
    localparam logic [LAT_W-1:0] LAT_ILL = 2'd3;

    localparam int unsigned FF_NV = 4;
    localparam int unsigned FF_DZ = 3;
    localparam int unsigned FF_OF = 2;
    localparam int unsigned FF_UF = 1;
    localparam int unsigned FF_NX = 0;

    typedef struct packed {
        logic              vld;
        logic [LAT_W-1:0]  lat;
        logic              done;
        logic [DATA_W-1:0] data;
        logic [FF_W-1:0]   fflags;
    } entry_t;

endpackage

// File: rtl/aq_vfmau_wb_match.sv
// Oldest-pending finder: returns the first entry, searching from the head,
// that is valid, not yet done and belongs to lat class cls_i.
//   vld_i/pend_i/lat_i : per-entry state vectors
//   cls_i              : lat class served by this completion port
//   head_i             : head index (search start)
//   onehot_o/hit_o     : matching entry and whether one exists
module aq_vfmau_wb_match
    import aq_vfmau_wb_collect_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic [DEPTH-1:0]            vld_i,
    input  logic [DEPTH-1:0]            pend_i,
    input  logic [DEPTH-1:0][LAT_W-1:0] lat_i,
    input  logic [LAT_W-1:0]            cls_i,
    input  logic [AW-1:0]               head_i,
    output logic [DEPTH-1:0]            onehot_o,
    output logic                        hit_o
);

    logic [DEPTH-1:0] cand;
    logic [AW-1:0]    idx;

    // Rotating priority search starting at the head
    always_comb begin
        onehot_o = '0;
        hit_o    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cand[i] = vld_i[i] && pend_i[i] && (lat_i[i] == cls_i);
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i + AW'(k);
            if (!hit_o && cand[idx]) begin
                onehot_o[idx] = 1'b1;
                hit_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aq_vfmau_wb_collect.sv
// In-order result collector for the vector FMA pipe.
//   ex1_alloc_*          : allocate tail entry (lat class, dest tag); alloc_rdy = not full
//   vfmau_vpu_ex{3,4,5}_*: stage result ports; each completes the oldest pending entry of its class
//   wb_*                 : head entry to writeback over valid/ready
//   fflags_clr/acc       : sticky OR of flags of popped entries
//   flush                : drop all entries, pointers to zero
//   protocol_err         : sticky; unmatched completion, illegal lat, or alloc while full
module aq_vfmau_wb_collect
    import aq_vfmau_wb_collect_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PREG_W = 6
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              ex1_alloc_vld,
    input  logic [LAT_W-1:0]  ex1_alloc_lat,
    input  logic [PREG_W-1:0] ex1_alloc_preg,
    output logic              alloc_rdy,
    input  logic              vfmau_vpu_ex3_result_vld,
    input  logic              vfmau_vpu_ex4_result_vld,
    input  logic              vfmau_vpu_ex5_result_vld,
    input  logic [DATA_W-1:0] vfmau_vpu_ex3_fpr_result,
    input  logic [DATA_W-1:0] vfmau_vpu_ex4_fpr_result,
    input  logic [DATA_W-1:0] vfmau_vpu_ex5_fpr_result,
    input  logic [FF_W-1:0]   vfmau_vpu_ex3_fflags,
    input  logic [FF_W-1:0]   vfmau_vpu_ex4_fflags,
    input  logic [FF_W-1:0]   vfmau_vpu_ex5_fflags,
    output logic              wb_vld,
    output logic [DATA_W-1:0] wb_data,
    output logic [PREG_W-1:0] wb_preg,
    output logic [FF_W-1:0]   wb_fflags,
    input  logic              wb_rdy,
    input  logic              fflags_clr,
    output logic [FF_W-1:0]   fflags_acc,
    input  logic              flush,
    output logic              protocol_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t [DEPTH-1:0]             ent_q, ent_d;
    logic   [DEPTH-1:0][PREG_W-1:0] preg_q, preg_d;
    logic   [PW-1:0]                head_q, head_d, tail_q, tail_d;
    logic                           alloc_rdy_q, alloc_rdy_d;
    logic   [FF_W-1:0]              ffacc_q, ffacc_d;
    logic                           perr_q, perr_d;

    logic [AW-1:0] hidx, tidx;
    logic          pop, alloc_ok;

    logic [DEPTH-1:0]            ent_vld, ent_pend;
    logic [DEPTH-1:0][LAT_W-1:0] ent_lat;

    logic [NSTAGE-1:0]             res_vld;
    logic [NSTAGE-1:0][DATA_W-1:0] res_data;
    logic [NSTAGE-1:0][FF_W-1:0]   res_ff;
    logic [NSTAGE-1:0][DEPTH-1:0]  m_oh;
    logic [NSTAGE-1:0]             m_hit;

    assign res_vld  = {vfmau_vpu_ex5_result_vld, vfmau_vpu_ex4_result_vld, vfmau_vpu_ex3_result_vld};
    assign res_data = {vfmau_vpu_ex5_fpr_result, vfmau_vpu_ex4_fpr_result, vfmau_vpu_ex3_fpr_result};
    assign res_ff   = {vfmau_vpu_ex5_fflags, vfmau_vpu_ex4_fflags, vfmau_vpu_ex3_fflags};

    assign hidx = head_q[AW-1:0];
    assign tidx = tail_q[AW-1:0];

    // Flatten entry state into the vectors the finders consume
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_vld[i]  = ent_q[i].vld;
            ent_pend[i] = !ent_q[i].done;
            ent_lat[i]  = ent_q[i].lat;
        end
    end

    // One finder per completion stage; stage s serves lat class s
    for (genvar s = 0; s < NSTAGE; s++) begin : g_match
        aq_vfmau_wb_match #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_match (
            .vld_i    (ent_vld),
            .pend_i   (ent_pend),
            .lat_i    (ent_lat),
            .cls_i    (LAT_W'(s)),
            .head_i   (hidx),
            .onehot_o (m_oh[s]),
            .hit_o    (m_hit[s])
        );
    end

    // Head view; stable under backpressure because only a pop moves the head
    assign wb_vld       = ent_q[hidx].vld && ent_q[hidx].done;
    assign wb_data      = ent_q[hidx].data;
    assign wb_fflags    = ent_q[hidx].fflags;
    assign wb_preg      = preg_q[hidx];
    assign alloc_rdy    = alloc_rdy_q;
    assign fflags_acc   = ffacc_q;
    assign protocol_err = perr_q;

    assign pop      = wb_vld && wb_rdy;
    assign alloc_ok = ex1_alloc_vld && alloc_rdy_q && (ex1_alloc_lat != LAT_ILL);

    // Next-state: completions, pop, alloc, flush, sticky flags
    always_comb begin
        ent_d   = ent_q;
        preg_d  = preg_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ffacc_d = ffacc_q;
        perr_d  = perr_q;

        // Clear first so a coincident pop leaves exactly the popped flags
        if (fflags_clr) ffacc_d = '0;
        if (pop)        ffacc_d = ffacc_d | ent_q[hidx].fflags;

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].vld  = 1'b0;
                ent_d[i].done = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (ex1_alloc_vld && (!alloc_rdy_q || (ex1_alloc_lat == LAT_ILL))) perr_d = 1'b1;
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                if (res_vld[s] && !m_hit[s]) perr_d = 1'b1;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (res_vld[s] && m_oh[s][i]) begin
                        ent_d[i].done   = 1'b1;
                        ent_d[i].data   = res_data[s];
                        ent_d[i].fflags = res_ff[s];
                    end
                end
            end
            if (pop) begin
                ent_d[hidx].vld  = 1'b0;
                ent_d[hidx].done = 1'b0;
                head_d           = head_q + PW'(1);
            end
            // Full rejects the alloc, so the tail never lands on the popping head
            if (alloc_ok) begin
                ent_d[tidx].vld    = 1'b1;
                ent_d[tidx].lat    = ex1_alloc_lat;
                ent_d[tidx].done   = 1'b0;
                ent_d[tidx].data   = '0;
                ent_d[tidx].fflags = '0;
                preg_d[tidx]       = ex1_alloc_preg;
                tail_d             = tail_q + PW'(1);
            end
        end

        alloc_rdy_d = !((tail_d[AW] != head_d[AW]) && (tail_d[AW-1:0] == head_d[AW-1:0]));
    end

    // State registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ent_q       <= '0;
            preg_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            alloc_rdy_q <= 1'b1;
            ffacc_q     <= '0;
            perr_q      <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            preg_q      <= preg_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            alloc_rdy_q <= alloc_rdy_d;
            ffacc_q     <= ffacc_d;
            perr_q      <= perr_d;
        end
    end

endmodule

// File: tb/tb_aq_vfmau_wb_collect.sv
// Directed bench for aq_vfmau_wb_collect: reset, single op, out-of-order completion,
// full queue with wrap, simultaneous completions, backpressure with flag clear,
// flush, and mid-operation reset.
module tb_aq_vfmau_wb_collect;
    import aq_vfmau_wb_collect_pkg::*;

    localparam int unsigned PREG_W = 6;

    logic              forever_cpuclk = 1'b0;
    logic              cpurst_b;
    logic              ex1_alloc_vld;
    logic [1:0]        ex1_alloc_lat;
    logic [PREG_W-1:0] ex1_alloc_preg;
    logic              alloc_rdy;
    logic              ex3_vld, ex4_vld, ex5_vld;
    logic [63:0]       ex3_data, ex4_data, ex5_data;
    logic [4:0]        ex3_ff, ex4_ff, ex5_ff;
    logic              wb_vld;
    logic [63:0]       wb_data;
    logic [PREG_W-1:0] wb_preg;
    logic [4:0]        wb_fflags;
    logic              wb_rdy;
    logic              fflags_clr;
    logic [4:0]        fflags_acc;
    logic              flush;
    logic              protocol_err;

    int errors = 0;
    int checks = 0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    aq_vfmau_wb_collect #(
        .DEPTH  (4),
        .PREG_W (PREG_W)
    ) dut (
        .forever_cpuclk           (forever_cpuclk),
        .cpurst_b                 (cpurst_b),
        .ex1_alloc_vld            (ex1_alloc_vld),
        .ex1_alloc_lat            (ex1_alloc_lat),
        .ex1_alloc_preg           (ex1_alloc_preg),
        .alloc_rdy                (alloc_rdy),
        .vfmau_vpu_ex3_result_vld (ex3_vld),
        .vfmau_vpu_ex4_result_vld (ex4_vld),
        .vfmau_vpu_ex5_result_vld (ex5_vld),
        .vfmau_vpu_ex3_fpr_result (ex3_data),
        .vfmau_vpu_ex4_fpr_result (ex4_data),
        .vfmau_vpu_ex5_fpr_result (ex5_data),
        .vfmau_vpu_ex3_fflags     (ex3_ff),
        .vfmau_vpu_ex4_fflags     (ex4_ff),
        .vfmau_vpu_ex5_fflags     (ex5_ff),
        .wb_vld                   (wb_vld),
        .wb_data                  (wb_data),
        .wb_preg                  (wb_preg),
        .wb_fflags                (wb_fflags),
        .wb_rdy                   (wb_rdy),
        .fflags_clr               (fflags_clr),
        .fflags_acc               (fflags_acc),
        .flush                    (flush),
        .protocol_err             (protocol_err)
    );

    // One clock: inputs held across the edge, outputs settled 1 time unit after
    task automatic cyc();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic idle_inputs();
        ex1_alloc_vld = 1'b0; ex1_alloc_lat = 2'd0; ex1_alloc_preg = '0;
        ex3_vld = 1'b0; ex4_vld = 1'b0; ex5_vld = 1'b0;
        ex3_data = '0; ex4_data = '0; ex5_data = '0;
        ex3_ff = '0; ex4_ff = '0; ex5_ff = '0;
        wb_rdy = 1'b0; fflags_clr = 1'b0; flush = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] lat, input logic [PREG_W-1:0] preg);
        ex1_alloc_vld = 1'b1; ex1_alloc_lat = lat; ex1_alloc_preg = preg;
        cyc();
        ex1_alloc_vld = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cpurst_b = 1'b0;
        #12;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy: got %0b exp 1", alloc_rdy); end
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL reset_wb_vld: got %0b exp 0", wb_vld); end
        checks++; if (wb_data !== 64'h0) begin errors++; $display("FAIL reset_wb_data: got %h exp 0", wb_data); end
        checks++; if (wb_preg !== 6'd0) begin errors++; $display("FAIL reset_wb_preg: got %0d exp 0", wb_preg); end
        checks++; if (wb_fflags !== 5'd0) begin errors++; $display("FAIL reset_wb_fflags: got %h exp 0", wb_fflags); end
        checks++; if (fflags_acc !== 5'd0) begin errors++; $display("FAIL reset_fflags_acc: got %h exp 0", fflags_acc); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b exp 0", protocol_err); end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        alloc(LAT_EX3, 6'd5);                         // cycle 0
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL single_c1_vld: got %0b exp 0", wb_vld); end
        cyc();                                        // cycle 1
        ex3_vld = 1'b1; ex3_data = 64'h3FF0000000000000; ex3_ff = 5'h01;
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL single_c2_vld: got %0b exp 0", wb_vld); end
        cyc();                                        // cycle 2 capture
        idle_inputs();
        checks++; if (wb_vld !== 1'b1) begin errors++; $display("FAIL single_c3_vld: got %0b exp 1", wb_vld); end
        checks++; if (wb_data !== 64'h3FF0000000000000) begin errors++; $display("FAIL single_data: got %h exp 3ff0000000000000", wb_data); end
        checks++; if (wb_preg !== 6'd5) begin errors++; $display("FAIL single_preg: got %0d exp 5", wb_preg); end
        checks++; if (wb_fflags !== 5'h01) begin errors++; $display("FAIL single_fflags: got %h exp 01", wb_fflags); end
        checks++; if (fflags_acc !== 5'h00) begin errors++; $display("FAIL single_acc_pre: got %h exp 00", fflags_acc); end
        wb_rdy = 1'b1;
        cyc();                                        // cycle 3 pop
        wb_rdy = 1'b0;
        checks++; if (fflags_acc !== 5'h01) begin errors++; $display("FAIL single_acc: got %h exp 01", fflags_acc); end
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL single_c4_vld: got %0b exp 0", wb_vld); end
    endtask

    task automatic test_ooo();
        alloc(LAT_EX5, 6'd10);
        alloc(LAT_EX3, 6'd11);
        ex3_vld = 1'b1; ex3_data = 64'h22; ex3_ff = 5'h02;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL ooo_young_done_vld: got %0b exp 0", wb_vld); end
        cyc();
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL ooo_wait_vld: got %0b exp 0", wb_vld); end
        ex5_vld = 1'b1; ex5_data = 64'h11; ex5_ff = 5'h04;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd10 || wb_data !== 64'h11) begin errors++;
            $display("FAIL ooo_first: got vld=%0b preg=%0d data=%h exp vld=1 preg=10 data=11", wb_vld, wb_preg, wb_data); end
        wb_rdy = 1'b1;
        cyc();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd11 || wb_data !== 64'h22) begin errors++;
            $display("FAIL ooo_second: got vld=%0b preg=%0d data=%h exp vld=1 preg=11 data=22", wb_vld, wb_preg, wb_data); end
        cyc();
        wb_rdy = 1'b0;
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL ooo_drained: got %0b exp 0", wb_vld); end
        checks++; if (fflags_acc !== 5'h07) begin errors++; $display("FAIL ooo_acc: got %h exp 07", fflags_acc); end
    endtask

    // Head sits at index 3 here, so filling the queue wraps the tail
    task automatic test_full();
        fflags_clr = 1'b1; cyc(); fflags_clr = 1'b0;
        alloc(LAT_EX3, 6'd1);
        alloc(LAT_EX3, 6'd2);
        alloc(LAT_EX3, 6'd3);
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_3: got %0b exp 1", alloc_rdy); end
        alloc(LAT_EX3, 6'd4);
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_4: got %0b exp 0", alloc_rdy); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL full_perr_pre: got %0b exp 0", protocol_err); end
        alloc(LAT_EX3, 6'd9);
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL full_perr_drop: got %0b exp 1", protocol_err); end
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_5: got %0b exp 0", alloc_rdy); end
        ex3_vld = 1'b1; ex3_data = 64'hAB; ex3_ff = 5'h00;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd1) begin errors++;
            $display("FAIL full_head: got vld=%0b preg=%0d exp vld=1 preg=1", wb_vld, wb_preg); end
        wb_rdy = 1'b1;
        cyc();
        wb_rdy = 1'b0;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop: got %0b exp 1", alloc_rdy); end
        flush = 1'b1; cyc(); flush = 1'b0;
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL full_flush_vld: got %0b exp 0", wb_vld); end
    endtask

    task automatic test_simul();
        fflags_clr = 1'b1; cyc(); fflags_clr = 1'b0;
        alloc(LAT_EX3, 6'd20);
        alloc(LAT_EX4, 6'd21);
        alloc(LAT_EX5, 6'd22);
        ex3_vld = 1'b1; ex3_data = 64'hA; ex3_ff = 5'h10;
        ex4_vld = 1'b1; ex4_data = 64'hB; ex4_ff = 5'h08;
        ex5_vld = 1'b1; ex5_data = 64'hC; ex5_ff = 5'h01;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd20 || wb_data !== 64'hA || wb_fflags !== 5'h10) begin errors++;
            $display("FAIL simul_pop0: got vld=%0b preg=%0d data=%h ff=%h exp 1/20/a/10", wb_vld, wb_preg, wb_data, wb_fflags); end
        wb_rdy = 1'b1;
        cyc();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd21 || wb_data !== 64'hB) begin errors++;
            $display("FAIL simul_pop1: got vld=%0b preg=%0d data=%h exp 1/21/b", wb_vld, wb_preg, wb_data); end
        cyc();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd22 || wb_data !== 64'hC) begin errors++;
            $display("FAIL simul_pop2: got vld=%0b preg=%0d data=%h exp 1/22/c", wb_vld, wb_preg, wb_data); end
        cyc();
        wb_rdy = 1'b0;
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL simul_drained: got %0b exp 0", wb_vld); end
        checks++; if (fflags_acc !== 5'h19) begin errors++; $display("FAIL simul_acc: got %h exp 19", fflags_acc); end
    endtask

    // Entries land at indices 3 and 0 (wrap); flags accumulated so far are 0x19
    task automatic test_back_pressure();
        alloc(LAT_EX4, 6'd40);
        alloc(LAT_EX3, 6'd41);
        ex4_vld = 1'b1; ex4_data = 64'hDEAD; ex4_ff = 5'h02;
        ex3_vld = 1'b1; ex3_data = 64'h41;   ex3_ff = 5'h08;
        cyc();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            checks++; if (wb_vld !== 1'b1 || wb_data !== 64'hDEAD || wb_preg !== 6'd40) begin errors++;
                $display("FAIL bp_stall%0d: got vld=%0b data=%h preg=%0d exp 1/dead/40", i, wb_vld, wb_data, wb_preg); end
            cyc();
        end
        wb_rdy = 1'b1;
        cyc();
        checks++; if (fflags_acc !== 5'h1B) begin errors++; $display("FAIL bp_acc_pop: got %h exp 1b", fflags_acc); end
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd41) begin errors++;
            $display("FAIL bp_next: got vld=%0b preg=%0d exp 1/41", wb_vld, wb_preg); end
        fflags_clr = 1'b1;
        cyc();
        idle_inputs();
        checks++; if (fflags_acc !== 5'h08) begin errors++; $display("FAIL bp_clr_pop: got %h exp 08", fflags_acc); end
    endtask

    task automatic test_flush();
        alloc(LAT_EX4, 6'd30);
        alloc(LAT_EX4, 6'd31);
        alloc(LAT_EX3, 6'd32);
        flush = 1'b1;
        ex4_vld = 1'b1; ex4_data = 64'h77; ex4_ff = 5'h10;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL flush_vld: got %0b exp 0", wb_vld); end
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %0b exp 1", alloc_rdy); end
        checks++; if (fflags_acc !== 5'h08) begin errors++; $display("FAIL flush_acc: got %h exp 08", fflags_acc); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL flush_idle%0d: got %0b exp 0", i, wb_vld); end
        end
        alloc(LAT_EX3, 6'd33);
        ex3_vld = 1'b1; ex3_data = 64'h33; ex3_ff = 5'h00;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b1 || wb_preg !== 6'd33 || wb_data !== 64'h33) begin errors++;
            $display("FAIL flush_reuse: got vld=%0b preg=%0d data=%h exp 1/33/33", wb_vld, wb_preg, wb_data); end
        wb_rdy = 1'b1; cyc(); wb_rdy = 1'b0;
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL flush_reuse_pop: got %0b exp 0", wb_vld); end
    endtask

    task automatic test_reset_mid();
        alloc(LAT_EX3, 6'd50);
        ex3_vld = 1'b1; ex3_data = 64'h50; ex3_ff = 5'h04;
        cyc();
        idle_inputs();
        checks++; if (wb_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre_vld: got %0b exp 1", wb_vld); end
        #2;
        cpurst_b = 1'b0;
        #1;
        checks++; if (wb_vld !== 1'b0 || fflags_acc !== 5'h00 || protocol_err !== 1'b0 || alloc_rdy !== 1'b1) begin errors++;
            $display("FAIL rmid_async: got vld=%0b acc=%h perr=%0b rdy=%0b exp 0/00/0/1", wb_vld, fflags_acc, protocol_err, alloc_rdy); end
        cyc();
        cpurst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL rmid_idle%0d: got %0b exp 0", i, wb_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ooo();
        test_full();
        test_simul();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a wedged run still ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
